// File: rtl/plane_recip_div_if.sv
// Handshake bundle between the scanline renderer and the reciprocal unit.
//   start : single-cycle request, denom sampled on the same edge
//   denom : unsigned divisor (DEN_W bits)
//   recip : registered result, held between operations (OUT_W bits)
//   busy  : operation in progress
//   done  : one-cycle pulse when recip has just been updated
interface plane_recip_div_if #(
  parameter int unsigned DEN_W = 9,
  parameter int unsigned OUT_W = 11
);
  logic             start;
  logic [DEN_W-1:0] denom;
  logic [OUT_W-1:0] recip;
  logic             busy;
  logic             done;

  modport master (output start, output denom, input recip, input busy, input done);
  modport slave  (input start, input denom, output recip, output busy, output done);
endinterface

// File: rtl/plane_recip_div.sv
// Sequential reciprocal: recip = min(floor(2^NUM_SHIFT / denom), 2^OUT_W-1).
// Radix-2 restoring division, one quotient bit per clock, fixed OUT_W-cycle latency.
//   clk48 : 48 MHz pixel clock
//   rst   : asynchronous reset, active-high
//   bus   : slave side of plane_recip_div_if (start/denom in, recip/busy/done out)
module plane_recip_div #(
  parameter int unsigned DEN_W     = 9,
  parameter int unsigned OUT_W     = 11,
  parameter int unsigned NUM_SHIFT = 16
) (
  input  logic              clk48,
  input  logic              rst,
  plane_recip_div_if.slave  bus
);

  localparam int unsigned REM_W     = DEN_W + 1;
  localparam int unsigned CMP_W     = DEN_W + 2;
  localparam int unsigned CNT_W     = $clog2(OUT_W + 1);
  localparam int unsigned SAT_SHIFT = NUM_SHIFT - OUT_W;

  // Upper bits of the numerator 2^NUM_SHIFT; the low OUT_W zero bits are shifted in by iteration.
  localparam logic [REM_W-1:0] REM_INIT = REM_W'(1) << SAT_SHIFT;

  typedef enum logic {IDLE, DIV} state_e;

  state_e             state_q, state_d;
  logic [DEN_W-1:0]   den_q,   den_d;
  logic [REM_W-1:0]   rem_q,   rem_d;
  logic [OUT_W-1:0]   quo_q,   quo_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               sat_q,   sat_d;
  logic [OUT_W-1:0]   recip_q, recip_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;

  logic [CMP_W-1:0]   trial;
  logic               ge;
  logic [REM_W-1:0]   diff;
  logic [OUT_W-1:0]   quo_next;

  // Next-state and datapath for one restoring-division step.
  always_comb begin
    state_d = state_q;
    den_d   = den_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    recip_d = recip_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    trial    = CMP_W'(rem_q) << 1;
    ge       = (trial >= CMP_W'(den_q));
    diff     = REM_W'(trial - CMP_W'(den_q));
    quo_next = {quo_q[OUT_W-2:0], ge};

    if (bus.start) begin
      // A new request always wins, including over an op in its final cycle.
      den_d   = bus.denom;
      sat_d   = (REM_W'(bus.denom) <= REM_INIT);
      rem_d   = REM_INIT;
      quo_d   = '0;
      cnt_d   = CNT_W'(OUT_W);
      busy_d  = 1'b1;
      state_d = DIV;
    end else if (state_q == DIV) begin
      rem_d = ge ? diff : REM_W'(trial);
      quo_d = quo_next;
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        // A set bit shifted out of quo_q also means the quotient overflowed.
        recip_d = (sat_q || quo_q[OUT_W-1]) ? {OUT_W{1'b1}} : quo_next;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk48 or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      den_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      recip_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      den_q   <= den_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      recip_q <= recip_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.recip = recip_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_plane_recip_div.sv
// Randomized scoreboard bench for plane_recip_div.
module tb_plane_recip_div;

  localparam int DEN_W = 9;
  localparam int OUT_W = 11;
  localparam int LAT   = 11;
  localparam int MAXQ  = 2047;

  logic clk48 = 1'b0;
  logic rst   = 1'b1;
  always #10 clk48 = ~clk48;

  plane_recip_div_if #(.DEN_W(DEN_W), .OUT_W(OUT_W)) bus ();

  plane_recip_div #(.DEN_W(DEN_W), .OUT_W(OUT_W), .NUM_SHIFT(16)) dut (
    .clk48 (clk48),
    .rst   (rst),
    .bus   (bus)
  );

  typedef struct {
    int due;
    int val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass  = 0;
  int   last_val = 0;
  int   b0_s = 0, b0_e = 0, b1_s = 0, b1_e = 0;

  always @(posedge clk48) cyc <= cyc + 1;

  function automatic int ref_recip(int d);
    int q;
    if (d == 0) return MAXQ;
    q = 65536 / d;
    return (q > MAXQ) ? MAXQ : q;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
  endtask

  // Monitor: every cycle out of reset, compare busy/done/recip against the model.
  always @(negedge clk48) begin
    bit exp_done, exp_busy;
    if (!rst) begin
      exp_done = (sb.size() > 0) && (sb[0].due == cyc);
      exp_busy = ((b0_s <= cyc) && (cyc < b0_e)) || ((b1_s <= cyc) && (cyc < b1_e));
      chk("done", int'(bus.done), int'(exp_done));
      chk("busy", int'(bus.busy), int'(exp_busy));
      if (exp_done) begin
        chk("recip", int'(bus.recip), sb[0].val);
        last_val = sb[0].val;
        void'(sb.pop_front());
      end else begin
        chk("recip_hold", int'(bus.recip), last_val);
      end
    end
  end

  // Called at posedge+2; the request is sampled on the next edge. Returns that edge's number.
  task automatic issue(input int d, output int t_start);
    exp_t e;
    t_start = cyc + 1;
    while (sb.size() > 0 && sb[$].due >= t_start) void'(sb.pop_back());
    b0_s = b1_s;
    b0_e = (b1_e < t_start) ? b1_e : t_start;
    b1_s = t_start;
    b1_e = t_start + LAT;
    e.due = t_start + LAT;
    e.val = ref_recip(d);
    sb.push_back(e);
    bus.start = 1'b1;
    bus.denom = DEN_W'(d);
    @(posedge clk48); #2;
    bus.start = 1'b0;
    bus.denom = DEN_W'($urandom);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk48); #2;
    end
  endtask

  task automatic run_one(input int d);
    int t;
    issue(d, t);
    wait_cyc(t + LAT + 2);
  endtask

  int fixed_d[8] = '{300, 33, 32, 1, 0, 511, 257, 34};

  initial begin
    int t, d;
    bus.start = 1'b0;
    bus.denom = '0;
    #5;
    chk("rst_recip", int'(bus.recip), 0);
    chk("rst_busy",  int'(bus.busy),  0);
    chk("rst_done",  int'(bus.done),  0);
    @(posedge clk48); #2;
    rst = 1'b0;
    repeat (2) begin @(posedge clk48); #2; end

    // Directed values, including saturation and the denom==0 corner.
    foreach (fixed_d[i]) run_one(fixed_d[i]);

    // Restart mid-operation: only the second result may appear.
    issue(300, t);
    wait_cyc(t + 4);
    issue(511, t);
    wait_cyc(t + LAT + 2);

    // Restart on the final edge of an op.
    issue(100, t);
    wait_cyc(t + LAT - 1);
    issue(40, t);
    wait_cyc(t + LAT + 2);

    // Asynchronous reset mid-operation.
    issue(200, t);
    wait_cyc(t + 5);
    #1 rst = 1'b1;
    #1;
    chk("arst_recip", int'(bus.recip), 0);
    chk("arst_busy",  int'(bus.busy),  0);
    chk("arst_done",  int'(bus.done),  0);
    sb.delete();
    last_val = 0;
    b0_s = 0; b0_e = 0; b1_s = 0; b1_e = 0;
    // A request during reset must be ignored.
    bus.start = 1'b1;
    bus.denom = DEN_W'(77);
    @(posedge clk48); #2;
    bus.start = 1'b0;
    @(posedge clk48); #2;
    rst = 1'b0;
    wait_cyc(cyc + LAT + 4);

    // Back-to-back random ops, each new start in the previous done cycle.
    issue(int'($urandom_range(0, 511)), t);
    for (int i = 0; i < 20; i++) begin
      wait_cyc(t + LAT);
      d = (i % 3 == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 511));
      issue(d, t);
    end
    wait_cyc(t + LAT + 3);

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
